// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the dual-lane SPI link: word/lane widths, FSM encodings,
// debug view and the lane mapping used by both transmitter and receiver.
package spi_pkg;
    localparam int SPI_WORD_W         = 16;
    localparam int SPI_LANE_W         = 8;
    localparam int SPI_BITS_PER_FRAME = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    typedef struct packed {
        logic [2:0] state;
        logic [2:0] bit_cnt;
        logic       sck_tick;
        logic       sck_rise;
    } spi_dbg_t;

    // Lane 1 carries the low byte, lane 2 the high byte.
    function automatic logic [SPI_LANE_W-1:0] spi_lane1(input logic [SPI_WORD_W-1:0] w);
        return w[SPI_LANE_W-1:0];
    endfunction

    function automatic logic [SPI_LANE_W-1:0] spi_lane2(input logic [SPI_WORD_W-1:0] w);
        return w[SPI_WORD_W-1:SPI_LANE_W];
    endfunction

    function automatic logic [SPI_WORD_W-1:0] spi_join(input logic [SPI_LANE_W-1:0] l2,
                                                       input logic [SPI_LANE_W-1:0] l1);
        return {l2, l1};
    endfunction
endpackage

// File: rtl/spi_master_tx_if.sv
`timescale 1ns/1ps
// Producer handshake and SPI pin bundle for spi_master_tx.
// i_start is a request taken in any cycle o_busy=0; while o_busy=1 requests are dropped, not queued.
interface spi_master_tx_if;
    import spi_pkg::*;

    logic                  i_start;
    logic [SPI_WORD_W-1:0] i_data;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_sck;
    logic                  o_cs;
    logic                  o_tx_ch1;
    logic                  o_tx_ch2;

    modport master (
        input  i_start, i_data,
        output o_busy, o_done, o_sck, o_cs, o_tx_ch1, o_tx_ch2
    );

    modport slave (
        output i_start, i_data,
        input  o_busy, o_done, o_sck, o_cs, o_tx_ch1, o_tx_ch2
    );
endinterface

// File: rtl/spi_sck_gen.sv
`timescale 1ns/1ps
// Serial clock generator: CLK_DIV-cycle half periods while enabled, sck forced low otherwise.
// o_rise/o_fall flag the cycle before sck changes level.
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_tick,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] r_cnt;
    logic          r_sck;

    assign o_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise = o_tick && !r_sck;
    assign o_fall = o_tick && r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (o_tick) begin
            r_cnt <= '0;
            r_sck <= ~r_sck;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master_tx.sv
`timescale 1ns/1ps
// Dual-lane SPI transmitter: one 16-bit word per frame, low byte on ch1, high byte on ch2,
// MSB first, data launched on sck falling edges.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    spi_master_tx_if.master bus,
    output spi_dbg_t        o_dbg
);
    localparam int T_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int T_MAX  = (T_MAX0 > CS_IDLE) ? T_MAX0 : CS_IDLE;
    localparam int TW     = $clog2(T_MAX + 1);

    logic [2:0]            r_state;
    logic [SPI_WORD_W-1:0] r_shift;
    logic [2:0]            r_bit_cnt;
    logic [TW-1:0]         r_tmr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cs;

    logic                  w_sck_en, w_sck, w_tick, w_rise, w_fall, w_tmr_end;
    logic [TW-1:0]         w_tmr_lim;
    logic [SPI_LANE_W-1:0] w_l1, w_l2;

    assign w_sck_en = (r_state == ST_SHIFT);

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_en   (w_sck_en),
        .o_sck  (w_sck),
        .o_tick (w_tick),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_comb begin
        w_tmr_lim = '0;
        case (r_state)
            ST_SETUP: w_tmr_lim = TW'(CS_SETUP - 1);
            ST_HOLD:  w_tmr_lim = TW'(CS_HOLD - 1);
            ST_GAP:   w_tmr_lim = TW'(CS_IDLE - 1);
            default:  ;
        endcase
    end

    assign w_tmr_end = (r_tmr == w_tmr_lim);
    assign w_l1      = spi_lane1(r_shift);
    assign w_l2      = spi_lane2(r_shift);

    // Lane pins are the shift-register MSBs; clearing the register at cs rise idles them low.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tmr     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cs      <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmr <= '0;
                    if (bus.i_start) begin
                        r_shift <= bus.i_data;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b0;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_tmr <= r_tmr + 1'b1;
                    if (w_tmr_end) begin
                        r_tmr   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_fall) begin
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'(SPI_BITS_PER_FRAME - 1)) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_shift <= spi_join({w_l2[SPI_LANE_W-2:0], 1'b0},
                                                {w_l1[SPI_LANE_W-2:0], 1'b0});
                        end
                    end
                end
                ST_HOLD: begin
                    r_tmr <= r_tmr + 1'b1;
                    if (w_tmr_end) begin
                        r_tmr   <= '0;
                        r_cs    <= 1'b1;
                        r_done  <= 1'b1;
                        r_shift <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_tmr <= r_tmr + 1'b1;
                    if (w_tmr_end) begin
                        r_tmr   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_cs     = r_cs;
    assign bus.o_sck    = w_sck;
    assign bus.o_tx_ch1 = w_l1[SPI_LANE_W-1];
    assign bus.o_tx_ch2 = w_l2[SPI_LANE_W-1];

    assign o_dbg = '{state: r_state, bit_cnt: r_bit_cnt, sck_tick: w_tick, sck_rise: w_rise};
endmodule

// File: tb/tb_spi_master_tx.sv
`timescale 1ns/1ps
// Bench for spi_master_tx: directed frames into a default-timing DUT checked by a
// receiver-model monitor, plus a minimum-timing DUT sending one word.
module tb_spi_master_tx;
    import spi_pkg::*;

    localparam int CD         = 4;
    localparam int SU         = 2;
    localparam int HD         = 2;
    localparam int ID         = 2;
    localparam int CS_LOW_LEN = SU + 16 * CD + HD;
    localparam int BUSY_LEN   = CS_LOW_LEN + ID;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc     = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    spi_master_tx_if bus_a();
    spi_master_tx_if bus_b();
    spi_dbg_t        dbg_a;
    spi_dbg_t        dbg_b;

    spi_master_tx #(.CLK_DIV(CD), .CS_SETUP(SU), .CS_HOLD(HD), .CS_IDLE(ID)) dut_a (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_a),
        .o_dbg   (dbg_a)
    );

    spi_master_tx #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) dut_b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_b),
        .o_dbg   (dbg_b)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] exp_q[$];     // {check cs gap before this frame, word}
    logic [15:0] exp_b_q[$];
    bit          expect_abort = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // ---------------- monitor: receiver model for dut_a ----------------
    logic        p_sck = 1'b0, p_cs = 1'b1, p_busy = 1'b0, p_ch1 = 1'b0, p_ch2 = 1'b0;
    bit          in_frame = 1'b0, busy_trk = 1'b0;
    int          last_chg = 0, last_done = -1000, cs_t0 = 0, busy_t0 = 0;
    int          rises = 0, hi_chg = 0, min_setup = 1000, frames = 0;
    logic [7:0]  rx1 = '0, rx2 = '0;
    logic [16:0] e_mon;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                in_frame = 1'b0;
                busy_trk = 1'b0;
            end else begin
                if (bus_a.o_tx_ch1 !== p_ch1 || bus_a.o_tx_ch2 !== p_ch2) begin
                    last_chg = cyc;
                    if (in_frame && bus_a.o_sck && p_sck) hi_chg++;
                end
                if (bus_a.o_busy && !p_busy) begin
                    busy_trk = 1'b1;
                    busy_t0  = cyc;
                end
                if (!bus_a.o_busy && p_busy && busy_trk) begin
                    busy_trk = 1'b0;
                    chk("busy_len", cyc - busy_t0, BUSY_LEN);
                end
                if (bus_a.o_done) chk("done_with_cs_rise", int'(bus_a.o_cs && !p_cs), 1);
                if (!bus_a.o_cs && p_cs) begin
                    if (!expect_abort) begin
                        chk("frame_expected", int'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0 && exp_q[0][16]) chk("cs_gap", cyc - last_done, ID + 1);
                    end
                    in_frame  = 1'b1;
                    cs_t0     = cyc;
                    rises     = 0;
                    hi_chg    = 0;
                    min_setup = 1000;
                    rx1       = '0;
                    rx2       = '0;
                end
                if (in_frame && bus_a.o_sck && !p_sck) begin
                    rises++;
                    rx1 = {rx1[6:0], bus_a.o_tx_ch1};
                    rx2 = {rx2[6:0], bus_a.o_tx_ch2};
                    if (cyc - last_chg < min_setup) min_setup = cyc - last_chg;
                end
                if (in_frame && bus_a.o_cs && !p_cs) begin
                    in_frame  = 1'b0;
                    last_done = cyc;
                    frames++;
                    e_mon = exp_q.pop_front();
                    chk("done_at_cs_rise", int'(bus_a.o_done), 1);
                    chk("cs_low_len", cyc - cs_t0, CS_LOW_LEN);
                    chk("sck_rises", rises, 8);
                    chk("lane_setup_ok", int'(min_setup >= CD), 1);
                    chk("lane_change_sck_high", hi_chg, 0);
                    chk("word", int'({rx2, rx1}), int'(e_mon[15:0]));
                end
            end
            p_sck  = bus_a.o_sck;
            p_cs   = bus_a.o_cs;
            p_busy = bus_a.o_busy;
            p_ch1  = bus_a.o_tx_ch1;
            p_ch2  = bus_a.o_tx_ch2;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_busy_a(input logic v, input string nm);
        int n = 0;
        while (bus_a.o_busy !== v && n < 400) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk(nm, int'(bus_a.o_busy), int'(v));
    endtask

    task automatic send_a(input logic [15:0] d, input bit push, input bit gap);
        wait_busy_a(1'b0, "idle_before_send");
        bus_a.i_start = 1'b1;
        bus_a.i_data  = d;
        if (push) exp_q.push_back({gap, d});
        @(posedge sys_clk); #1;
        bus_a.i_start = 1'b0;
        bus_a.i_data  = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_rises(input int target, input string nm);
        int n = 0;
        while (rises != target && n < 400) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk(nm, rises, target);
    endtask

    // ---------------- stimulus ----------------
    int          frames_before;
    int          nb_hi, nb_rise, nb_last, nb_per_bad;
    logic        pb_sck, pb_cs;
    logic [7:0]  rxb1, rxb2;
    logic [15:0] e_b;

    initial begin
        bus_a.i_start = 1'b0;
        bus_a.i_data  = '0;
        bus_b.i_start = 1'b0;
        bus_b.i_data  = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_outputs_a", int'({bus_a.o_cs, bus_a.o_sck, bus_a.o_tx_ch1, bus_a.o_tx_ch2,
                                     bus_a.o_busy, bus_a.o_done}), 6'b100000);
        chk("reset_state_a", int'(dbg_a.state), int'(ST_IDLE));
        chk("reset_outputs_b", int'({bus_b.o_cs, bus_b.o_sck, bus_b.o_busy}), 3'b100);
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        repeat (2) begin @(posedge sys_clk); #1; end

        // single frames with distinct bit patterns
        send_a(16'hA55A, 1'b1, 1'b0);
        wait_busy_a(1'b0, "a55a_end");
        chk("bitcnt_wrap", int'(dbg_a.bit_cnt), 0);
        send_a(16'h0000, 1'b1, 1'b0);
        send_a(16'hFFFF, 1'b1, 1'b0);
        send_a(16'h8001, 1'b1, 1'b0);
        wait_busy_a(1'b0, "patterns_end");

        // back-to-back with i_start held high
        bus_a.i_data  = 16'hA1B2;
        bus_a.i_start = 1'b1;
        exp_q.push_back({1'b0, 16'hA1B2});
        wait_busy_a(1'b1, "b2b_acc1");
        bus_a.i_data = 16'hC3D4;
        exp_q.push_back({1'b1, 16'hC3D4});
        wait_busy_a(1'b0, "b2b_gap1");
        wait_busy_a(1'b1, "b2b_acc2");
        bus_a.i_data = 16'hE5F6;
        exp_q.push_back({1'b1, 16'hE5F6});
        wait_busy_a(1'b0, "b2b_gap2");
        wait_busy_a(1'b1, "b2b_acc3");
        bus_a.i_start = 1'b0;
        wait_busy_a(1'b0, "b2b_end");

        // start pulse during bit 4 with new data: dropped
        frames_before = frames;
        send_a(16'h3C96, 1'b1, 1'b0);
        wait_rises(4, "busy_pulse_wait");
        bus_a.i_start = 1'b1;
        bus_a.i_data  = 16'hFFFF;
        @(posedge sys_clk); #1;
        bus_a.i_start = 1'b0;
        wait_busy_a(1'b0, "busy_pulse_end");
        repeat (10) begin @(posedge sys_clk); #1; end
        chk("start_while_busy_dropped", frames - frames_before, 1);
        chk("still_idle", int'(bus_a.o_busy), 0);

        // reset during the 4th sck high phase
        expect_abort = 1'b1;
        send_a(16'h5A5A, 1'b0, 1'b0);
        wait_rises(4, "rst_wait");
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_mid_outputs", int'({bus_a.o_cs, bus_a.o_sck, bus_a.o_tx_ch1, bus_a.o_tx_ch2,
                                     bus_a.o_busy, bus_a.o_done}), 6'b100000);
        chk("rst_mid_state", int'(dbg_a.state), int'(ST_IDLE));
        @(posedge sys_clk); #1;
        sys_rst      = 1'b0;
        expect_abort = 1'b0;
        @(posedge sys_clk); #1;
        send_a(16'h1357, 1'b1, 1'b0);
        wait_busy_a(1'b0, "after_rst_end");

        // minimum-timing configuration
        bus_b.i_data  = 16'h1234;
        bus_b.i_start = 1'b1;
        exp_b_q.push_back(16'h1234);
        @(posedge sys_clk); #1;
        bus_b.i_start = 1'b0;
        pb_sck = 1'b0; pb_cs = 1'b1;
        nb_hi = 0; nb_rise = 0; nb_last = -1; nb_per_bad = 0;
        rxb1 = '0; rxb2 = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge sys_clk);
            if (!bus_b.o_busy) break;
            nb_hi++;
            if (bus_b.o_sck && !pb_sck) begin
                nb_rise++;
                if (nb_last >= 0 && cyc - nb_last != 2) nb_per_bad++;
                nb_last = cyc;
                rxb1 = {rxb1[6:0], bus_b.o_tx_ch1};
                rxb2 = {rxb2[6:0], bus_b.o_tx_ch2};
            end
            if (bus_b.o_cs && !pb_cs) begin
                e_b = exp_b_q.pop_front();
                chk("b_done_at_cs_rise", int'(bus_b.o_done), 1);
                chk("b_word", int'({rxb2, rxb1}), int'(e_b));
            end
            pb_sck = bus_b.o_sck;
            pb_cs  = bus_b.o_cs;
        end
        chk("b_frame_len", nb_hi + 1, 20);
        chk("b_rises", nb_rise, 8);
        chk("b_sck_period", nb_per_bad, 0);
        chk("b_state_idle", int'(dbg_b.state), int'(ST_IDLE));

        repeat (4) @(posedge sys_clk);
        chk("a_queue_drained", exp_q.size(), 0);
        chk("b_queue_drained", exp_b_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
